onehot_rr_arbiter: RTL and testbench
====================================

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 The block SHALL have parameter PTR_INIT, default 2'd0, meaning the index of the highest-priority line after reset.
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req_in  input  4  per-line request, sampled every clk edge, level or single-cycle pulse.
REQ-005 The block SHALL have port out_onehot  output  4  granted line, one-hot, feeds the downstream 4-to-2 encoder.
REQ-006 The block SHALL have port out_valid  output  1  out_onehot holds a grant.
REQ-007 The block SHALL have port out_ready  input  1  downstream accepts out_onehot this cycle.
REQ-008 The block SHALL have port overrun  output  4  one-cycle pulse per line when a request merges into an already-pending one.
REQ-009 The block SHALL have port busy  output  1  any request is pending or a grant is held.

Function
REQ-010 The block SHALL keep a 4-bit pending register; pending[i] is set at an edge where req_in[i]=1.
REQ-011 The block SHALL guarantee out_onehot is all-zero when out_valid=0 and has exactly one bit set when out_valid=1.
REQ-012 The block SHALL load a new grant at an edge where out_valid=0 or (out_valid=1 and out_ready=1).
REQ-013 The block SHALL select the grant from the registered pending value only; a req_in bit arriving in the same cycle is not eligible until the next cycle.
REQ-014 The block SHALL select round-robin: the first set pending bit searching upward from ptr, wrapping 3->0.
REQ-015 The block SHALL, on loading grant index g, clear pending[g], set out_onehot to 1<<g and out_valid to 1, and set ptr to (g+1) mod 4.
REQ-016 The block SHALL, when a load is permitted and pending is zero, drive out_valid=0 and out_onehot=4'b0000, leaving ptr unchanged.
REQ-017 The block SHALL hold out_onehot, out_valid and ptr stable while out_valid=1 and out_ready=0.
REQ-018 The block SHALL keep pending[g] set when req_in[g]=1 in the same cycle that g is granted; the set wins and no overrun is flagged.
REQ-019 The block SHALL pulse overrun[i] for one cycle, registered, when req_in[i]=1, pending[i]=1 and pending[i] is not cleared that cycle.
REQ-020 The block SHALL give a minimum latency of 2 edges from req_in sampled to out_valid=1, with the output idle and no other requests pending.
REQ-021 The block SHALL sustain one grant per cycle while out_ready=1 and pending stays non-zero.
REQ-022 The block SHALL drive busy combinationally as (|pending) | out_valid.

Reset
REQ-023 The block SHALL, on rst_n=0 at any time, asynchronously clear pending, out_onehot, out_valid and overrun, and set ptr=PTR_INIT.
REQ-024 The block SHALL discard a held un-accepted grant on reset mid-operation, without replaying it.
REQ-025 The block SHALL resume sampling at the first rising clk edge after rst_n deasserts.

Structure
REQ-026 The block SHALL take line count (4), index width (2) and the all-zero code from a shared include file, onehot_arb_defs.vh.
REQ-027 The block SHALL implement the round-robin search as one combinational sub-module, rr_pick (inputs pending and ptr; outputs one-hot select and index).

Verification
REQ-028 The bench SHALL cover: reset, then a req_in=4'b0100 pulse with out_ready=1 -> out_onehot=4'b0100 and out_valid=1 exactly 2 edges later, then idle at 4'b0000.
REQ-029 The bench SHALL cover: req_in=4'b1111 for one cycle, out_ready=1, PTR_INIT=0 -> grants 0001, 0010, 0100, 1000 on consecutive cycles, then busy=0.
REQ-030 The bench SHALL cover: a grant of 4'b0010 held with out_ready=0 for 5 cycles while req_in=4'b0001 arrives -> output stable; after out_ready=1 the next grant is 4'b0001.
REQ-031 The bench SHALL cover: req_in[3] pulsed twice while pending[3]=1 and out_ready=0 -> overrun=4'b1000 for one cycle each time, with a single grant of 4'b1000 after release.
REQ-032 The bench SHALL cover: req_in[1]=1 in the cycle line 1 is granted -> no overrun, and a second 4'b0010 grant follows.
REQ-033 The bench SHALL cover: rst_n asserted low mid-cycle with out_valid=1 and pending=4'b1010 -> all outputs 0 immediately, and no grant after release until a new request.

Source files
------------

// File: rtl/onehot_rr_arbiter_pkg.sv
// ============================================================================
// Module   : onehot_rr_arbiter_pkg
// Brief    : Shared types and constants for the one-hot round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`include "onehot_arb_defs.vh"

package onehot_rr_arbiter_pkg;
  localparam int c_LINES = `ARB_LINES;
  localparam int c_IDX_W = `ARB_IDX_W;

  typedef logic [c_LINES-1:0] line_vec_t;
  typedef logic [c_IDX_W-1:0] line_idx_t;

  localparam line_vec_t c_NONE = `ARB_NONE;

  // Pointer advance wraps naturally through the index width.
  function automatic line_idx_t next_idx(input line_idx_t idx);
    return idx + line_idx_t'(1);
  endfunction
endpackage

`default_nettype wire

// File: rtl/onehot_arb_defs.vh
// Shared sizing constants for the one-hot round-robin arbiter.
`ifndef ONEHOT_ARB_DEFS_VH
`define ONEHOT_ARB_DEFS_VH
`define ARB_LINES 4
`define ARB_IDX_W 2
`define ARB_NONE  4'b0000
`endif

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first set bit at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import onehot_rr_arbiter_pkg::*;
(
  input  logic [c_LINES-1:0] i_pending,
  input  logic [c_IDX_W-1:0] i_ptr,
  output logic [c_LINES-1:0] o_sel,
  output logic [c_IDX_W-1:0] o_idx,
  output logic               o_any
);

  line_idx_t w_cand [c_LINES];

  for (genvar g = 0; g < c_LINES; g++) begin : g_cand
    assign w_cand[g] = i_ptr + line_idx_t'(g);
  end

  always_comb begin
    o_sel = c_NONE;
    o_idx = i_ptr;
    o_any = 1'b0;
    for (int k = 0; k < c_LINES; k++) begin
      if (!o_any && i_pending[w_cand[k]]) begin
        o_any = 1'b1;
        o_idx = w_cand[k];
        o_sel = line_vec_t'(1) << w_cand[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
// ============================================================================
// Module   : onehot_rr_arbiter
// Brief    : 4-line round-robin arbiter with pending capture and one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter logic [c_IDX_W-1:0] PTR_INIT = 2'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_LINES-1:0] req_in,
  output logic [c_LINES-1:0] out_onehot,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [c_LINES-1:0] overrun,
  output logic               busy
);

  line_vec_t r_pending;
  line_idx_t r_ptr;
  line_vec_t r_onehot;
  logic      r_valid;
  line_vec_t r_overrun;

  logic      w_load;
  line_vec_t w_sel;
  line_idx_t w_idx;
  logic      w_any;
  line_vec_t w_clr;
  line_vec_t w_pending_nxt;
  line_vec_t w_overrun_nxt;

  rr_pick u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_sel     (w_sel),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  assign w_load = !r_valid || out_ready;
  assign w_clr  = (w_load && w_any) ? w_sel : c_NONE;

  // A same-cycle request re-sets the line being granted, so set wins over clear.
  assign w_pending_nxt = (r_pending & ~w_clr) | req_in;
  assign w_overrun_nxt = req_in & r_pending & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= c_NONE;
      r_ptr     <= PTR_INIT;
      r_onehot  <= c_NONE;
      r_valid   <= 1'b0;
      r_overrun <= c_NONE;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_load) begin
        if (w_any) begin
          r_onehot <= w_sel;
          r_valid  <= 1'b1;
          r_ptr    <= next_idx(w_idx);
        end else begin
          r_onehot <= c_NONE;
          r_valid  <= 1'b0;
        end
      end
    end
  end

  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;
  assign overrun    = r_overrun;
  assign busy       = (|r_pending) | r_valid;

endmodule

`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
// ============================================================================
// Module   : tb_onehot_rr_arbiter
// Brief    : Directed, table-driven self-checking bench for onehot_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_rr_arbiter;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] oh;
    logic       v;
    logic [3:0] ov;
    logic       b;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic       out_valid;
  logic [3:0] overrun;
  logic       busy;

  int   checks;
  int   errors;
  vec_t vecs[$];

  onehot_rr_arbiter #(.PTR_INIT(2'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                     input logic [3:0] oh, input logic v, input logic [3:0] ov,
                     input logic b);
    vec_t t;
    t.rst_n = r; t.req = rq; t.rdy = rd;
    t.oh = oh; t.v = v; t.ov = ov; t.b = b;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [3:0] oh, input logic v,
                     input logic [3:0] ov, input logic b);
    checks++;
    if ({out_onehot, out_valid, overrun, busy} !== {oh, v, ov, b}) begin
      errors++;
      $display("FAIL %s: got onehot=%b valid=%b overrun=%b busy=%b, want onehot=%b valid=%b overrun=%b busy=%b",
               nm, out_onehot, out_valid, overrun, busy, oh, v, ov, b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_in = 4'b0000;
    out_ready = 1'b0;
    #12;
    chk("reset", 4'b0000, 1'b0, 4'b0000, 1'b0);

    // single pulse: grant two edges later, then idle
    add(1, 4'b0100, 1, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0100, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // reset back to ptr 0, then all four lines in rotation
    add(0, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    add(1, 4'b1111, 1, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0001, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0100, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b1000, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // grant 0010 held five cycles while line 0 arrives
    add(1, 4'b0010, 0, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0001, 0, 4'b0010, 1, 4'b0000, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b0000, 0, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0001, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // line 3 overruns twice behind a held grant, granted once
    add(1, 4'b0100, 0, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1000, 0, 4'b0100, 1, 4'b0000, 1);
    add(1, 4'b1000, 0, 4'b0100, 1, 4'b1000, 1);
    add(1, 4'b0000, 0, 4'b0100, 1, 4'b0000, 1);
    add(1, 4'b1000, 0, 4'b0100, 1, 4'b1000, 1);
    add(1, 4'b0000, 1, 4'b1000, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // re-request on the granting cycle: no overrun, second grant
    add(1, 4'b0010, 1, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b0010, 1, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0010, 1, 4'b0000, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0);
    // set up held grant with pending 1010 for the mid-cycle reset
    add(1, 4'b0100, 0, 4'b0000, 0, 4'b0000, 1);
    add(1, 4'b1010, 0, 4'b0100, 1, 4'b0000, 1);

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      req_in    = vecs[i].req;
      out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vecs[i].oh, vecs[i].v, vecs[i].ov, vecs[i].b);
    end

    // asynchronous reset between edges clears everything at once
    req_in = 4'b0000;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 1'b0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_idle%0d", i), 4'b0000, 1'b0, 4'b0000, 1'b0);
    end
    req_in = 4'b0010;
    @(posedge clk);
    #1;
    chk("post_rst_req", 4'b0000, 1'b0, 4'b0000, 1'b1);
    req_in = 4'b0000;
    @(posedge clk);
    #1;
    chk("post_rst_grant", 4'b0010, 1'b1, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
